// File: rtl/bf16_acc_seq_if.sv
// Operand stream, external adder hookup and result stream for bf16_acc_seq.
// The accumulator owns the slave side; the surrounding logic drives the master side.
interface bf16_acc_seq_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic [15:0]          in_data;
   logic                 in_last;
   logic                 in_ready;

   logic [15:0]          add_a;
   logic [15:0]          add_b;
   logic [2:0]           add_rnd;
   logic [15:0]          add_z;

   logic                 out_valid;
   logic [15:0]          out_data;
   logic [CNT_WIDTH-1:0] out_count;
   logic                 out_ready;

   modport master (
      output in_valid, in_data, in_last, add_z, out_ready,
      input  in_ready, add_a, add_b, add_rnd, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, add_z, out_ready,
      output in_ready, add_a, add_b, add_rnd, out_valid, out_data, out_count
   );
endinterface

// File: rtl/bf16_acc_seq.sv
// Sums a stream of bfloat16 operands per group using an external combinational adder
// and presents the sum with a saturating operand count.
//
//   state  | meaning
//   IDLE   | waiting for the first operand of a group
//   ACC    | group in progress, acc holds the running sum
//   HOLD   | group sum presented, waiting for out_ready
module bf16_acc_seq #(
   parameter int sig_width = 7,
   parameter int exp_width = 8,
   parameter int CNT_WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   bf16_acc_seq_if.slave bus
);

   if (sig_width != 7) begin : g_bad_sig_width
      $fatal(1, "bf16_acc_seq: sig_width must be 7");
   end
   if (exp_width != 8) begin : g_bad_exp_width
      $fatal(1, "bf16_acc_seq: exp_width must be 8");
   end

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [1:0]           state_q, state_d;
   logic [15:0]          acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 in_ready;
   logic                 accept;

   assign in_ready = (state_q != S_HOLD);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = bus.in_data;
               cnt_d   = CNT_ONE;
               state_d = bus.in_last ? S_HOLD : S_ACC;
            end
         end
         S_ACC: begin
            if (accept) begin
               // adder result is stored verbatim, including NaN/Inf/denormals
               acc_d   = bus.add_z;
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
               state_d = bus.in_last ? S_HOLD : S_ACC;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= 16'h0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.add_a     = acc_q;
   assign bus.add_b     = bus.in_data;
   assign bus.add_rnd   = 3'b000;
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.out_data  = acc_q;
   assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_bf16_acc_seq.sv
// Bench for bf16_acc_seq: directed group table, multi-cycle corner sequences and a
// randomized run against a group-level reference model, with an attached bf16 adder.
module tb_bf16_acc_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bf16_acc_seq_if #(.CNT_WIDTH(8)) b1 ();
   bf16_acc_seq_if #(.CNT_WIDTH(2)) b2 ();

   bf16_acc_seq #(.sig_width(7), .exp_width(8), .CNT_WIDTH(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));
   bf16_acc_seq #(.sig_width(7), .exp_width(8), .CNT_WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(b2));

   int checks = 0;
   int errors = 0;

   // bfloat16 <-> real for normal values and zero, round-to-nearest-even on the way back
   function automatic real bf2r(input logic [15:0] b);
      logic [63:0] d;
      logic [10:0] e;
      if (b[14:0] == 15'd0) return 0.0;
      e = 11'(b[14:7]) + 11'd896;
      d = {b[15], e, b[6:0], 45'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [15:0] r2bf(input real r);
      logic [63:0] d;
      logic [14:0] v;
      logic [44:0] rem;
      logic [44:0] half;
      int e;
      if (r == 0.0) return 16'h0000;
      d    = $realtobits(r);
      e    = int'(d[62:52]) - 896;
      rem  = d[44:0];
      half = 45'd1 << 44;
      v    = {e[7:0], d[51:45]};
      if (rem > half || (rem == half && v[0])) v = v + 15'd1;
      return {d[63], v};
   endfunction

   function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
      return r2bf(bf2r(a) + bf2r(b));
   endfunction

   always_comb b1.add_z = bf16_add(b1.add_a, b1.add_b);
   always_comb b2.add_z = bf16_add(b2.add_a, b2.add_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          n;
      logic [15:0] ops [6];
      logic [15:0] exp_data;
      int          exp_cnt;
   } vec_t;

   vec_t vecs [5];

   task automatic run_vec(input vec_t v);
      b1.out_ready = 1'b1;
      for (int i = 0; i < v.n; i++) begin
         b1.in_valid = 1'b1;
         b1.in_data  = v.ops[i];
         b1.in_last  = (i == v.n - 1);
         #1;
         chk("vec_in_ready", 32'(b1.in_ready), 32'd1);
         tick();
         if (i == 0) chk("vec_add_a_first", 32'(b1.add_a), 32'(v.ops[0]));
         if (i < v.n - 1) chk("vec_out_valid_mid", 32'(b1.out_valid), 32'd0);
      end
      b1.in_valid = 1'b0;
      b1.in_last  = 1'b0;
      #1;
      chk("vec_out_valid", 32'(b1.out_valid), 32'd1);
      chk("vec_out_data", 32'(b1.out_data), 32'(v.exp_data));
      chk("vec_out_count", 32'(b1.out_count), 32'(v.exp_cnt));
      chk("vec_in_ready_hold", 32'(b1.in_ready), 32'd0);
      tick();
      chk("vec_out_valid_drop", 32'(b1.out_valid), 32'd0);
      chk("vec_in_ready_idle", 32'(b1.in_ready), 32'd1);
   endtask

   function automatic logic [15:0] rand_bf();
      logic [7:0] e;
      logic [6:0] m;
      logic       s;
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(120, 134));
      m = 7'($urandom_range(0, 127));
      return {s, e, m};
   endfunction

   logic        m_have;
   logic [15:0] m_sum, m_exp;
   int          m_n, m_cnt;

   initial begin
      b1.in_valid = 1'b0; b1.in_data = 16'h0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.in_data = 16'h0; b2.in_last = 1'b0; b2.out_ready = 1'b1;

      vecs[0] = '{n: 3, ops: '{16'h3F80, 16'h4000, 16'h4040, 16'h0, 16'h0, 16'h0}, exp_data: 16'h40C0, exp_cnt: 3};
      vecs[1] = '{n: 1, ops: '{16'hBF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, exp_data: 16'hBF00, exp_cnt: 1};
      vecs[2] = '{n: 4, ops: '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0, 16'h0}, exp_data: 16'h4080, exp_cnt: 4};
      vecs[3] = '{n: 2, ops: '{16'h4000, 16'hC000, 16'h0, 16'h0, 16'h0, 16'h0}, exp_data: 16'h0000, exp_cnt: 2};
      vecs[4] = '{n: 6, ops: '{16'h3F00, 16'h3E80, 16'h3E80, 16'h4000, 16'hBF80, 16'h4040}, exp_data: 16'h40A0, exp_cnt: 6};

      // reset state
      #2;
      chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
      chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
      chk("rst_add_a", 32'(b1.add_a), 32'h0);
      chk("rst_add_rnd", 32'(b1.add_rnd), 32'h0);
      b1.in_data = 16'h1234;
      #1;
      chk("add_b_follows_in_data", 32'(b1.add_b), 32'h1234);
      tick();
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // input gaps
      b1.in_valid = 1'b1; b1.in_data = 16'h3F00; b1.in_last = 1'b0;
      tick();
      b1.in_valid = 1'b0; b1.in_data = 16'h7777;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gap_out_valid", 32'(b1.out_valid), 32'd0);
         chk("gap_in_ready", 32'(b1.in_ready), 32'd1);
         chk("gap_add_a_held", 32'(b1.add_a), 32'h3F00);
      end
      b1.in_valid = 1'b1; b1.in_data = 16'h3F00; b1.in_last = 1'b1;
      tick();
      b1.in_valid = 1'b0; b1.in_last = 1'b0;
      chk("gap_out_data", 32'(b1.out_data), 32'h3F80);
      chk("gap_out_count", 32'(b1.out_count), 32'd2);
      tick();

      // downstream backpressure; offered operands must not be taken while holding
      b1.out_ready = 1'b0;
      b1.in_valid = 1'b1; b1.in_data = 16'h3F80; b1.in_last = 1'b0;
      tick();
      b1.in_last = 1'b1;
      tick();
      b1.in_data = 16'h4500; b1.in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", 32'(b1.out_valid), 32'd1);
         chk("bp_out_data", 32'(b1.out_data), 32'h4000);
         chk("bp_out_count", 32'(b1.out_count), 32'd2);
         chk("bp_in_ready", 32'(b1.in_ready), 32'd0);
      end
      b1.in_valid = 1'b0;
      b1.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(b1.out_valid), 32'd0);
      chk("bp_release_ready", 32'(b1.in_ready), 32'd1);

      // mid-group reset between edges
      b1.in_valid = 1'b1; b1.in_data = 16'h4000; b1.in_last = 1'b0;
      tick();
      tick();
      b1.in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(b1.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(b1.out_valid), 32'd0);
      chk("midrst_acc", 32'(b1.add_a), 32'h0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("midrst_no_pulse", 32'(b1.out_valid), 32'd0);
      run_vec('{n: 1, ops: '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, exp_data: 16'h4000, exp_cnt: 1});

      // count saturation on the narrow-counter instance
      b2.in_valid = 1'b1; b2.in_data = 16'h3F80;
      for (int i = 0; i < 5; i++) begin
         b2.in_last = (i == 4);
         tick();
      end
      b2.in_valid = 1'b0; b2.in_last = 1'b0;
      chk("sat_out_valid", 32'(b2.out_valid), 32'd1);
      chk("sat_out_count", 32'(b2.out_count), 32'd3);
      chk("sat_out_data", 32'(b2.out_data), 32'h40A0);
      tick();
      chk("sat_out_valid_drop", 32'(b2.out_valid), 32'd0);

      // randomized traffic against the group-level model
      m_have = 1'b0; m_n = 0; m_sum = 16'h0; m_exp = 16'h0; m_cnt = 0;
      for (int c = 0; c < 800; c++) begin
         b1.in_valid  = ($urandom_range(0, 3) != 0);
         b1.in_data   = rand_bf();
         b1.in_last   = ($urandom_range(0, 3) == 0);
         b1.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_in_ready", 32'(b1.in_ready), 32'(!m_have));
         chk("rnd_out_valid", 32'(b1.out_valid), 32'(m_have));
         chk("rnd_add_b", 32'(b1.add_b), 32'(b1.in_data));
         if (m_have) begin
            chk("rnd_out_data", 32'(b1.out_data), 32'(m_exp));
            chk("rnd_out_count", 32'(b1.out_count), 32'(m_cnt));
         end
         if (m_have) begin
            if (b1.out_ready) m_have = 1'b0;
         end else if (b1.in_valid) begin
            m_sum = (m_n == 0) ? b1.in_data : bf16_add(m_sum, b1.in_data);
            m_n++;
            if (b1.in_last) begin
               m_have = 1'b1;
               m_exp  = m_sum;
               m_cnt  = (m_n > 255) ? 255 : m_n;
               m_n    = 0;
            end
         end
         tick();
      end
      b1.in_valid = 1'b0;
      b1.out_ready = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
